// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder for the pipeline MEM stage. It accepts
//             one load/store request at a time over a valid/ready channel,
//             accesses a word-addressed RAM with byte-enable writes after a
//             programmable latency, and returns the result over a
//             valid/ready response channel. Misaligned and out-of-range
//             addresses are flagged instead of accessing the array.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 32,  // number of 32-bit words, power of two, >= 2
  parameter int LATENCY = 2    // accept edge to resp_valid high, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;
  logic           enter_resp;

  // Request fields latched on the acceptance edge
  logic           write_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     be_q;

  // Registered response payload
  logic [31:0]    rdata_q;
  logic           err_q;

  logic [31:0]    mem_q [DEPTH];

  // Fields used by the array access. With LATENCY==1 the access happens on
  // the acceptance edge itself, so the live request inputs are used while
  // still in IDLE; otherwise the latched copy is used.
  logic           a_write;
  logic [31:0]    a_addr;
  logic [31:0]    a_wdata;
  logic [3:0]     a_be;
  logic [AW-1:0]  a_index;
  logic           a_err;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Select live or latched request fields and decode the address
  always_comb begin
    a_write = write_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_be    = be_q;
    if (state_q == IDLE) begin
      a_write = req_write;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
    end
    a_index = a_addr[AW+1:2];
    a_err   = (|a_addr[1:0]) || (|a_addr[31:AW+2]);
  end

  // Next-state logic: handshakes, latency countdown and response hand-off
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch, memory array and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        err_q   <= a_err;
        rdata_q <= (!a_err && !a_write) ? mem_q[a_index] : 32'h0;
        if (!a_err && a_write) begin
          for (int b = 0; b < 4; b++) begin
            if (a_be[b]) begin
              mem_q[a_index][8*b +: 8] <= a_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (LATENCY=2 and =1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1, resp_ready1;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid1),
    .req_ready  (req_ready1),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid1),
    .resp_ready (resp_ready1),
    .resp_rdata (resp_rdata1),
    .resp_err   (resp_err1)
  );

  // Reference behaviour: word RAM addressed by byte address / 4
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, output logic e, output logic [31:0] r);
    int idx;
    e = (a % 4 != 0) || (a >= 4 * DEPTH);
    r = 32'h0;
    if (!e) begin
      idx = a / 4;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        r = model[idx];
      end
    end
  endtask

  task automatic clear_model;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // One complete transaction on the LATENCY=2 instance with optional stall
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int stall);
    logic        e_exp;
    logic [31:0] r_exp;
    int          n;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_idle: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    model_access(w, a, d, be, e_exp, r_exp);
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 2) begin
      n_bad++; $display("FAIL latency addr=%h: cycles=%0d expected 2", a, n);
    end
    n_cmp++;
    if (resp_rdata !== r_exp || resp_err !== e_exp) begin
      n_bad++;
      $display("FAIL resp w=%b addr=%h: rdata=%h err=%b expected rdata=%h err=%b",
               w, a, resp_rdata, resp_err, r_exp, e_exp);
    end
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_write = 1'($urandom); req_addr = {25'h0, 5'($urandom), 2'b00};
      req_wdata = $urandom; req_be = 4'hF;
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== r_exp || resp_err !== e_exp) begin
        n_bad++;
        $display("FAIL stall%0d: valid=%b ready=%b rdata=%h err=%b expected 1 0 %h %b",
                 s, resp_valid, req_ready, resp_rdata, resp_err, r_exp, e_exp);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release: resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; resp_ready = 1'b0; resp_ready1 = 1'b1;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        req_ready1 !== 1'b0 || resp_valid1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b ready1=%b valid1=%b expected 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, req_ready1, resp_valid1);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || req_ready1 !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b ready1=%b valid=%b expected 1 1 0", req_ready, req_ready1, resp_valid);
    end
    clear_model();
  endtask

  task automatic test_directed;
    xact(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
    xact(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0);
    xact(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);
    xact(1'b1, 32'h0000_0008, 32'h1122_3344, 4'b0101, 0);
    xact(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);
    n_cmp++;
    if (model[2] !== 32'hDE22_BE44) begin
      n_bad++; $display("FAIL model_merge: got %h expected DE22BE44", model[2]);
    end
    xact(1'b1, 32'h0000_000C, 32'h5555_AAAA, 4'b0000, 0);
    xact(1'b0, 32'h0000_000C, 32'h0, 4'h0, 0);
  endtask

  task automatic test_errors;
    xact(1'b0, 32'h0000_0006, 32'h0, 4'h0, 0);
    xact(1'b0, 32'h0000_0080, 32'h0, 4'h0, 0);
    xact(1'b1, 32'h0000_0009, 32'hFFFF_FFFF, 4'hF, 0);
    xact(1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 4'hF, 0);
    xact(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);
  endtask

  task automatic test_backpressure;
    xact(1'b0, 32'h0000_0008, 32'h0, 4'h0, 5);
    xact(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 5);
    xact(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int          sel;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = {25'h0, 5'($urandom), 2'b00};
      else if (sel == 7) a = {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 8) a = ($urandom | 32'h80) & ~32'h3;
      else               a = $urandom;
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end
    for (int i = 0; i < DEPTH; i++) xact(1'b0, 32'(i * 4), 32'h0, 4'h0, 0);
  endtask

  task automatic test_back_to_back;
    int acc[$];
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h0000_0008; req_valid = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (req_valid && req_ready) acc.push_back(c);
      if (resp_valid) begin
        n_cmp++;
        if (resp_rdata !== model[2] || resp_err !== 1'b0) begin
          n_bad++; $display("FAIL b2b_data: rdata=%h err=%b expected %h 0", resp_rdata, resp_err, model[2]);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++;
    if (acc.size() < 6) begin
      n_bad++; $display("FAIL b2b_count: accepts=%0d expected >=6", acc.size());
    end
    for (int k = 1; k < acc.size(); k++) begin
      n_cmp++;
      if (acc[k] - acc[k-1] != 3) begin
        n_bad++; $display("FAIL b2b_period: gap=%0d expected 3", acc[k] - acc[k-1]);
      end
    end
    for (int c = 0; c < 10 && !(req_ready && !resp_valid); c++) @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drain: ready=%b valid=%b expected 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_back_to_back_lat1;
    int acc[$];
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h0000_0014; req_valid1 = 1'b1; resp_ready1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (req_valid1 && req_ready1) acc.push_back(c);
      if (resp_valid1) begin
        n_cmp++;
        if (resp_rdata1 !== 32'h0 || resp_err1 !== 1'b0) begin
          n_bad++; $display("FAIL b2b1_data: rdata=%h err=%b expected 0 0", resp_rdata1, resp_err1);
        end
      end
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    n_cmp++;
    if (acc.size() < 7) begin
      n_bad++; $display("FAIL b2b1_count: accepts=%0d expected >=7", acc.size());
    end
    for (int k = 1; k < acc.size(); k++) begin
      n_cmp++;
      if (acc[k] - acc[k-1] != 2) begin
        n_bad++; $display("FAIL b2b1_period: gap=%0d expected 2", acc[k] - acc[k-1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0004;
    req_wdata = 32'hCAFE_F00D; req_be = 4'hF; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_ready: req_ready=%b expected 0", req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_bad++; $display("FAIL mid_reset_noresp: resp_valid=%b expected 0", resp_valid);
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    xact(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0);
    xact(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_back_to_back_lat1();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves load/store requests from the pipeline memory stage over a valid/ready request channel and a valid/ready response channel.
- Holds a word-addressed RAM with byte-enable writes and a programmable access latency.
- Sits between the MEM stage (initiator) and the memory array, replacing the zero-latency combinational array access.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, >= 2.
- LATENCY, 2, cycles from request acceptance edge to resp_valid high; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables wdata[8i+7:8i]; ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - all DEPTH words cleared to 0; state = IDLE; latency counter = 0.
  - Outputs: req_ready=0 during the reset cycle, 1 in the first cycle after reset deasserts; resp_valid=0, resp_rdata=0, resp_err=0.
- Handshakes:
  - Request accepted on an edge where req_valid && req_ready.
  - Response consumed on an edge where resp_valid && resp_ready.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1, resp_valid=0. On acceptance, latch write, addr, wdata and be. Go to RESP if LATENCY==1, else load counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement counter each cycle; when counter==1, go to RESP on that edge.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err are held stable until the handshake. On the handshake edge, go to IDLE.
- Memory access:
  - Performed on the edge of transition into RESP.
  - Load: resp_rdata is captured from memfile[index].
  - Store: memfile[index] bytes with be=1 are updated; bytes with be=0 are unchanged; resp_rdata=0.
  - Store with be=4'b0000 is legal: no memory change, normal response.
- Address decode:
  - index = req_addr[AW+1:2], where AW = log2(DEPTH).
  - Error if req_addr[1:0]!=0 or any of req_addr[31:AW+2] is nonzero.
  - On error: no memory access, resp_err=1, resp_rdata=0, same latency as a normal access.
- Latency: resp_valid first rises exactly LATENCY cycles after the acceptance edge.
- Throughput: one outstanding request. The next request can be accepted no earlier than the cycle after the response handshake, so the minimum period is LATENCY+1 cycles.
- Back-pressure: resp_ready low holds RESP indefinitely with outputs stable. req_valid is ignored while req_ready=0.
- req_* inputs are sampled only on the acceptance edge; later changes have no effect.
- Reset mid-operation:
  - Pending request is discarded.
  - A store not yet committed is not written.
  - The array is cleared regardless.
- No combinational path from req_* or resp_ready to any output; all outputs are registered or decoded from state.

Test Plan:
- Reset, then load from addr 0x0000_0010, LATENCY=2 -> resp_valid high 2 cycles after accept; rdata=0x0000_0000; err=0.
- Store 0xDEAD_BEEF to 0x0000_0008 with be=4'hF, then load 0x0000_0008 -> rdata=0xDEAD_BEEF. Then store 0x1122_3344 with be=4'b0101, then load -> rdata=0xDE22_BE44.
- Load at 0x0000_0006 (misaligned) and at 0x0000_0080 (index out of range for DEPTH=32) -> err=1, rdata=0, memory unchanged, response 2 cycles after accept.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata, err stable; req_ready=0; a concurrent req_valid is not accepted. Release -> IDLE next cycle.
- Back-to-back requests with req_valid held high and resp_ready=1 -> accepts every LATENCY+1=3 cycles. Repeat with LATENCY=1 -> every 2 cycles.
- Assert reset in WAIT during a store of 0xCAFE_F00D to 0x0000_0004 -> no response; subsequent load of 0x0000_0004 returns 0.
